// File: rtl/control_test_pkg.sv
// rtl/control_test_pkg.sv - shared state enumeration and counter sizing for control_test
package control_test_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // One extra bit beyond log2(width) so the counter can represent width
    // itself and never wraps inside an operation.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/control_test_adder.sv
// rtl/control_test_adder.sv - combinational width-bit adder with carry in/out
//
// Ports:
//   cin  - carry in (set to 1 with b inverted to subtract)
//   a, b - operands
//   s    - sum, low width bits
//   cout - carry out (for subtraction: 1 means a >= original b)
module adder #(
    parameter int width = 32
) (
    input  logic             cin,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};

endmodule

// File: rtl/control_test.sv
// rtl/control_test.sv - sequencing FSM for a shift-add multiplier / shift-subtract divider
//
// Ports:
//   CLK      - rising-edge clock
//   Reset    - asynchronous, active-high reset
//   MCycleOp - 0 multiply, 1 divide (both take width shift steps)
//   Start    - level-sensitive operation request, sampled in IDLE
//   Control  - per-step decision bit from the datapath
//   Init     - datapath operand load strobe
//   Shift    - datapath shift-step strobe
//   Write    - commit adder result on this shift step
//   Busy     - operation in progress
//   Done     - one-cycle completion pulse
module control_test
    import control_test_pkg::*;
#(
    parameter int width = 32
) (
    input  logic CLK,
    input  logic Reset,
    input  logic MCycleOp,
    input  logic Start,
    input  logic Control,
    output logic Init,
    output logic Shift,
    output logic Write,
    output logic Busy,
    output logic Done
);

    localparam int CW = cnt_width(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    state_e        state;
    state_e        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // Multiply and divide share identical sequencing; the select only
    // matters to the datapath, so it is intentionally not consumed here.
    logic unused_op;
    assign unused_op = MCycleOp;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        Init       = 1'b0;
        Shift      = 1'b0;
        Write      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;

        case (state)
            IDLE: begin
                // Init/Busy follow Start combinationally so operands are
                // captured on the same edge that enters COMPUTE.
                if (Start) begin
                    Init       = 1'b1;
                    Busy       = 1'b1;
                    state_next = COMPUTE;
                    count_next = '0;
                end
            end
            COMPUTE: begin
                Shift      = 1'b1;
                Busy       = 1'b1;
                Write      = Control;
                count_next = count + 1'b1;
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_test.sv
// tb/tb_control_test.sv - self-checking bench for control_test and adder
module tb_control_test;

    localparam int W = 32;

    logic CLK;
    logic Reset;
    logic MCycleOp;
    logic Start;
    logic Control;
    logic Init, Shift, Write, Busy, Done;

    logic          a_cin;
    logic [W-1:0]  a_a, a_b, a_s;
    logic          a_cout;

    int compared;
    int mismatched;

    // Reference model: cycles elapsed since the Init cycle, -1 when idle.
    int since;

    control_test #(.width(W)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .MCycleOp(MCycleOp),
        .Start   (Start),
        .Control (Control),
        .Init    (Init),
        .Shift   (Shift),
        .Write   (Write),
        .Busy    (Busy),
        .Done    (Done)
    );

    adder #(.width(W)) u_add (
        .cin (a_cin),
        .a   (a_a),
        .b   (a_b),
        .s   (a_s),
        .cout(a_cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected {Init,Shift,Write,Busy,Done} from position within an operation:
    // Init cycle, then W shift cycles, then one Done cycle.
    function automatic logic [4:0] model_outs(input int s, input logic st, input logic ctl);
        if (s < 0)       return {st, 1'b0, 1'b0, st, 1'b0};
        else if (s <= W) return {1'b0, 1'b1, ctl, 1'b1, 1'b0};
        else             return 5'b00001;
    endfunction

    function automatic int model_next(input int s, input logic st);
        if (s < 0)          return st ? 1 : -1;
        else if (s == W + 1) return -1;
        else                return s + 1;
    endfunction

    task automatic drive(input logic st, input logic op, input logic ctl);
        @(negedge CLK);
        Start    = st;
        MCycleOp = op;
        Control  = ctl;
        #1;
    endtask

    task automatic test_reset;
        logic [4:0] obs;
        Reset = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Control = 1'b0;
        #1;
        obs = {Init, Shift, Write, Busy, Done};
        compared++;
        if (obs !== 5'b00000) begin
            $display("FAIL reset_outs: got %b want %b", obs, 5'b00000);
            mismatched++;
        end
        repeat (2) @(posedge CLK);
        drive(1'b0, 1'b0, 1'b1);
        obs = {Init, Shift, Write, Busy, Done};
        compared++;
        if (obs !== 5'b00000) begin
            $display("FAIL reset_held: got %b want %b", obs, 5'b00000);
            mismatched++;
        end
        Reset = 1'b0;
        since = -1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'($urandom));
            obs = {Init, Shift, Write, Busy, Done};
            compared++;
            if (obs !== model_outs(since, Start, Control)) begin
                $display("FAIL post_reset_idle[%0d]: got %b want %b", i, obs, model_outs(since, Start, Control));
                mismatched++;
            end
            since = model_next(since, Start);
        end
    endtask

    task automatic test_multiply_ones;
        logic [4:0] obs;
        int shifts, dones;
        shifts = 0; dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            drive(i == 0, 1'b0, 1'b1);
            obs = {Init, Shift, Write, Busy, Done};
            shifts += int'(Shift);
            dones  += int'(Done);
            compared++;
            if (obs !== model_outs(since, Start, Control)) begin
                $display("FAIL mul_ones[%0d]: got %b want %b", i, obs, model_outs(since, Start, Control));
                mismatched++;
            end
            since = model_next(since, Start);
        end
        compared++;
        if (shifts != W) begin
            $display("FAIL mul_shift_count: got %0d want %0d", shifts, W);
            mismatched++;
        end
        compared++;
        if (dones != 1) begin
            $display("FAIL mul_done_count: got %0d want 1", dones);
            mismatched++;
        end
    endtask

    task automatic test_multiply_toggle;
        logic [4:0] obs;
        for (int i = 0; i < W + 4; i++) begin
            drive(i == 0, 1'b0, 1'(i[0] == 1'b0));
            obs = {Init, Shift, Write, Busy, Done};
            compared++;
            if (obs !== model_outs(since, Start, Control)) begin
                $display("FAIL mul_toggle[%0d]: got %b want %b", i, obs, model_outs(since, Start, Control));
                mismatched++;
            end
            since = model_next(since, Start);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] obs;
        int first_init, second_init;
        first_init = -1; second_init = -1;
        for (int i = 0; i < 2 * (W + 2) + 2; i++) begin
            drive(1'b1, 1'b1, 1'($urandom));
            obs = {Init, Shift, Write, Busy, Done};
            if (Init === 1'b1) begin
                if (first_init < 0) first_init = i;
                else if (second_init < 0) second_init = i;
            end
            compared++;
            if (obs !== model_outs(since, Start, Control)) begin
                $display("FAIL div_b2b[%0d]: got %b want %b", i, obs, model_outs(since, Start, Control));
                mismatched++;
            end
            since = model_next(since, Start);
        end
        compared++;
        if (second_init - first_init != W + 2) begin
            $display("FAIL div_period: got %0d want %0d", second_init - first_init, W + 2);
            mismatched++;
        end
        // Drain to idle.
        for (int i = 0; i < W + 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            since = model_next(since, Start);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [4:0] obs;
        int dones;
        for (int i = 0; i < 11; i++) begin
            drive(i == 0, 1'b0, 1'b1);
            since = model_next(since, Start);
        end
        // Now at COMPUTE cycle 10.
        drive(1'b0, 1'b0, 1'b1);
        Reset = 1'b1;
        #1;
        obs = {Init, Shift, Write, Busy, Done};
        compared++;
        if (obs !== 5'b00000) begin
            $display("FAIL mid_reset_outs: got %b want %b", obs, 5'b00000);
            mismatched++;
        end
        since = -1;
        dones = 0;
        drive(1'b0, 1'b0, 1'b1);
        dones += int'(Done);
        Reset = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            drive(i == 1, 1'b0, 1'($urandom));
            obs = {Init, Shift, Write, Busy, Done};
            dones += int'(Done);
            compared++;
            if (obs !== model_outs(since, Start, Control)) begin
                $display("FAIL after_reset_op[%0d]: got %b want %b", i, obs, model_outs(since, Start, Control));
                mismatched++;
            end
            since = model_next(since, Start);
        end
        compared++;
        if (dones != 1) begin
            $display("FAIL after_reset_done_count: got %0d want 1", dones);
            mismatched++;
        end
    endtask

    task automatic test_random;
        logic [4:0] obs;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) == 0, 1'($urandom), 1'($urandom));
            obs = {Init, Shift, Write, Busy, Done};
            compared++;
            if (obs !== model_outs(since, Start, Control)) begin
                $display("FAIL random[%0d]: got %b want %b", i, obs, model_outs(since, Start, Control));
                mismatched++;
            end
            since = model_next(since, Start);
        end
    endtask

    task automatic test_adder;
        logic [W:0]   exp;
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W:0]   ve [3];
        va[0] = 32'd5;          vb[0] = ~32'd3; vc[0] = 1'b1; ve[0] = {1'b1, 32'd2};
        va[1] = 32'd3;          vb[1] = ~32'd5; vc[1] = 1'b1; ve[1] = {1'b0, 32'hFFFF_FFFE};
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'd1;  vc[2] = 1'b0; ve[2] = {1'b1, 32'd0};
        for (int i = 0; i < 3; i++) begin
            a_a = va[i]; a_b = vb[i]; a_cin = vc[i];
            #1;
            compared++;
            if ({a_cout, a_s} !== ve[i]) begin
                $display("FAIL adder_fixed[%0d]: got %h want %h", i, {a_cout, a_s}, ve[i]);
                mismatched++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            a_a = $urandom; a_b = $urandom; a_cin = 1'($urandom);
            exp = 33'(a_a) + 33'(a_b) + 33'(a_cin);
            #1;
            compared++;
            if ({a_cout, a_s} !== exp) begin
                $display("FAIL adder_rand[%0d]: got %h want %h", i, {a_cout, a_s}, exp);
                mismatched++;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        since      = -1;
        a_a = '0; a_b = '0; a_cin = 1'b0;
        test_reset;
        test_multiply_ones;
        test_multiply_toggle;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        test_adder;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_test.md
CONTROL_TEST -- requirements
Module: control_test

Interface
REQ-001 Parameter width, default 32, operand width; sets the iteration count of one operation.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 Reset  input  1  reset, asynchronous, active-high.
REQ-004 MCycleOp  input  1  operation select: 0 = multiply (shift-add), 1 = divide (shift-subtract).
REQ-005 Start  input  1  request to begin an operation; level-sensitive.
REQ-006 Control  input  1  per-iteration decision bit from the datapath:
  - multiply: multiplier LSB;
  - divide: subtractor carry-out (1 = remainder >= divisor).
REQ-007 Init  output  1  datapath load strobe; operands are captured at the next CLK edge.
REQ-008 Shift  output  1  datapath shift-step strobe.
REQ-009 Write  output  1  commit the adder result during this shift step.
REQ-010 Busy  output  1  operation in progress.
REQ-011 Done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have three states: IDLE, COMPUTE, DONE; its state and counter update on the CLK rising edge.
REQ-013 In IDLE with Start=1:
  - Init=1 and Busy=1, combinationally, in that same cycle;
  - next state is COMPUTE;
  - iteration counter clears to 0.
REQ-014 In IDLE with Start=0: Init=Shift=Write=Busy=Done=0.
REQ-015 In COMPUTE:
  - Shift=1 and Busy=1 every cycle;
  - Write=Control, combinationally;
  - counter increments each cycle.
REQ-016 COMPUTE SHALL last exactly width cycles for both MCycleOp values; after the cycle with counter=width-1, next state is DONE.
REQ-017 In DONE:
  - Done=1 and Busy=0 for exactly one cycle;
  - Init=Shift=Write=0;
  - next state is IDLE unconditionally; Start is ignored in DONE.
REQ-018 Start held high through DONE SHALL begin a new operation at the following IDLE cycle (Init again).
REQ-019 Start and MCycleOp changes during COMPUTE SHALL be ignored.
REQ-020 Write SHALL be 0 whenever Shift=0.
REQ-021 The counter SHALL be $clog2(width)+1 bits wide so that it never wraps before width.

Reset
REQ-022 Reset=1 SHALL immediately force IDLE, counter=0, and all outputs low except as REQ-013 permits, including mid-operation.
REQ-023 After Reset deasserts, the first CLK edge SHALL follow IDLE rules.

Structure
REQ-024 Shared package SHALL hold:
  - the state enumeration (IDLE, COMPUTE, DONE);
  - a counter-width function of width.
REQ-025 The sub-module adder SHALL be delivered with control_test and verified with it, but control_test does not instantiate it.
REQ-026 adder interface and behaviour:
  - ports: parameter width (default 32); inputs cin (1), a (width), b (width); outputs s (width), cout (1);
  - purely combinational: {cout,s} = a + b + cin, full width+1-bit result;
  - subtraction is performed by the user supplying ~b with cin=1.

Verification
REQ-027 width=32, MCycleOp=0, Start pulse one cycle, Control=1 -> Init and Busy high in the Start cycle, then 32 cycles Shift=1/Write=1/Busy=1, then Done=1/Busy=0 for one cycle, then idle.
REQ-028 Multiply, Control toggling 1,0,1,0... -> Write follows Control every COMPUTE cycle; Shift stays 1; Write=0 outside COMPUTE.
REQ-029 Divide (MCycleOp=1), Start held high continuously -> 32-cycle COMPUTE, 1-cycle DONE, then Init in the next IDLE cycle (period 34 cycles).
REQ-030 Reset asserted at COMPUTE cycle 10 -> all outputs low immediately; no Done; a new Start after release produces a full 32-cycle operation.
REQ-031 adder, width=32:
  - a=5, b=~3, cin=1 -> s=2, cout=1;
  - a=3, b=~5, cin=1 -> s=0xFFFFFFFE, cout=0;
  - a=0xFFFFFFFF, b=1, cin=0 -> s=0, cout=1.
